seq_signed_or_unsigned_mul: RTL

- Iterative (shift-add, radix-2) multiplier with a runtime signed/unsigned mode, generalised to any width n.
- Trades the combinational array multiplier for one partial-product step per clock. Used where area matters more than throughput.
- Valid/ready handshake on both sides. Mode is captured per transaction, so signed and unsigned operations may be freely interleaved.

---
 rtl/seq_signed_or_unsigned_mul.sv | 96 +++++++++
 1 files changed

// File: rtl/seq_signed_or_unsigned_mul.sv
// Radix-2 shift-add multiplier, one partial product per clock, with a per-transaction
// signed/unsigned mode. Signed operands are multiplied as magnitudes and the sign is applied at the end.
module seq_signed_or_unsigned_mul #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arg_vld,
  output logic           arg_rdy,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           signed_mul,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [2*n-1:0] res
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(n - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [2*n-1:0]   r_mcand;
  logic [2*n-1:0]   r_acc;
  logic [2*n-1:0]   r_res;
  logic [n-1:0]     r_mplier;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;
  logic [n-1:0]     w_magA;
  logic [n-1:0]     w_magB;
  logic [2*n-1:0]   w_accSum;
  logic             w_lastStep;

  // -2^(n-1) negates to 2^(n-1), which still fits as an n-bit unsigned magnitude.
  assign w_magA     = (signed_mul && a[n-1]) ? -a : a;
  assign w_magB     = (signed_mul && b[n-1]) ? -b : b;
  assign w_accSum   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_lastStep = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (arg_vld)    w_nextState = BUSY;
      BUSY:    if (w_lastStep) w_nextState = DONE;
      DONE:    if (res_rdy)    w_nextState = IDLE;
      default:                 w_nextState = IDLE;
    endcase
  end

  always_comb begin
    arg_rdy = (r_state == IDLE);
    res_vld = (r_state == DONE);
  end

  // The result register is written only on the final step, so it stays frozen through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_res    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (arg_vld) begin
            r_mcand  <= {{n{1'b0}}, w_magA};
            r_mplier <= w_magB;
            r_neg    <= signed_mul & (a[n-1] ^ b[n-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          r_acc    <= w_accSum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_lastStep) r_res <= r_neg ? -w_accSum : w_accSum;
        end
        default: ;
      endcase
    end
  end

  assign res = r_res;

endmodule
